csr_ctrl: RTL

CSR_CTRL -- requirements
Module: csr_ctrl

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_ctrl_if.sv | 27 ++
 rtl/csr_alu.sv | 21 ++
 rtl/csr_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types for the CSR instruction controller: FSM states, funct3 codes,
// CSR-file operation encodings and the latched request record.
package csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'd0,
    CSR_OP_SET   = 2'd1,
    CSR_OP_CLEAR = 2'd2,
    CSR_OP_READ  = 2'd3
  } csr_op_e;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [4:0]  rd_idx;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic [11:0] csr_adr;
  } csr_req_t;

  // Set/clear forms with rs1/zimm == 0 are pure reads and must not touch the CSR.
  function automatic logic wr_intent(input csr_req_t r);
    return (r.funct3[1:0] == 2'b01) || (r.rs1_idx != 5'd0);
  endfunction

  function automatic csr_op_e op_of(input logic [2:0] f3, input logic wint);
    if (!wint || f3[1:0] == 2'b00) return CSR_OP_READ;
    return csr_op_e'(f3[1:0] - 2'd1);
  endfunction

endpackage

// File: rtl/csr_ctrl_if.sv
// Request/response bus between the issue stage and the CSR controller.
interface csr_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic [11:0] csr_adr;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_rd_wdata;
  logic        rsp_rd_we;
  logic        rsp_illegal;

  modport master (
    output req_valid, funct3, rd_idx, rs1_idx, rs1_data, csr_adr, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd_idx, rsp_rd_wdata, rsp_rd_we, rsp_illegal
  );

  modport slave (
    input  req_valid, funct3, rd_idx, rs1_idx, rs1_data, csr_adr, rsp_ready,
    output req_ready, rsp_valid, rsp_rd_idx, rsp_rd_wdata, rsp_rd_we, rsp_illegal
  );
endinterface

// File: rtl/csr_alu.sv
// Combinational CSR write-data merge: write, set or clear against the old value.
module csr_alu
  import csr_pkg::*;
(
  input  csr_op_e     op_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] operand_i,
  output logic [31:0] wdata_o
);

  always_comb begin
    wdata_o = rdata_i;
    case (op_i)
      CSR_OP_WRITE: wdata_o = operand_i;
      CSR_OP_SET:   wdata_o = rdata_i | operand_i;
      CSR_OP_CLEAR: wdata_o = rdata_i & ~operand_i;
      default:      wdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// CSR instruction controller: latch request, read CSR, optional single write,
// then hold the writeback response until accepted.
module csr_ctrl
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  csr_ctrl_if.slave   bus,
  output logic [11:0] csr_adr_o,
  output logic [1:0]  csr_op_ctr_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_we_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        illegal_csr_i
);

  csr_state_e  state_q, state_d;
  csr_req_t    req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        illegal_q, illegal_d;

  logic        wint;
  logic        ill;
  logic [31:0] operand;
  csr_op_e     op_rw, op_out;
  logic [31:0] alu_wdata;
  logic        req_ready, rsp_valid, we;

  assign wint    = wr_intent(req_q);
  assign operand = req_q.funct3[2] ? {27'd0, req_q.rs1_idx} : req_q.rs1_data;
  assign op_rw   = op_of(req_q.funct3, wint);
  // Writes into the 0xC00-0xFFF range are illegal; reads there are fine.
  assign ill     = (req_q.funct3[1:0] == 2'b00) || illegal_csr_i ||
                   (wint && req_q.csr_adr[11:10] == 2'b11);

  csr_alu u_alu (
    .op_i     (op_rw),
    .rdata_i  (rdata_q),
    .operand_i(operand),
    .wdata_o  (alu_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    we        = 1'b0;
    op_out    = CSR_OP_READ;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          req_d.funct3   = bus.funct3;
          req_d.rd_idx   = bus.rd_idx;
          req_d.rs1_idx  = bus.rs1_idx;
          req_d.rs1_data = bus.rs1_data;
          req_d.csr_adr  = bus.csr_adr;
          state_d        = ST_READ;
        end
      end
      ST_READ: begin
        op_out    = op_rw;
        rdata_d   = csr_rdata_i;
        illegal_d = ill;
        state_d   = (ill || !wint) ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
        op_out  = op_rw;
        we      = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign csr_adr_o    = req_q.csr_adr;
  assign csr_op_ctr_o = op_out;
  assign csr_we_o     = we;
  assign csr_wdata_o  = we ? alu_wdata : 32'd0;

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_rd_idx   = req_q.rd_idx;
  assign bus.rsp_rd_wdata = rdata_q;
  assign bus.rsp_illegal  = illegal_q;
  assign bus.rsp_rd_we    = !illegal_q && (req_q.rd_idx != 5'd0);

endmodule
